// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle event strobes into fixed-length high
// windows on out_level. Events arriving while a window (or its trailing low
// gap) is active are counted and replayed in order; an event that finds the
// pending counter full is dropped and flagged on overflow for one cycle.
module pulse_stretcher #(
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int PEND_MAX    = 3,
  localparam int PW = $clog2(PEND_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_in,
  output logic          out_level,
  output logic          busy,
  output logic [PW-1:0] pending_cnt,
  output logic          overflow
);

  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_TOP = PW'(PEND_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // Window sequencer: state, down-counter, pending queue and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      out_level   <= 1'b0;
      busy        <= 1'b0;
      pending_cnt <= '0;
      overflow    <= 1'b0;
    end else begin
      overflow <= 1'b0;
      case (state)
        IDLE: begin
          if (pulse_in) begin
            state     <= HOLD;
            cnt       <= HOLD_LD;
            out_level <= 1'b1;
            busy      <= 1'b1;
          end
        end

        HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state     <= GAP;
            cnt       <= GAP_LD;
            out_level <= 1'b0;
          end
          // Any event during the high window has to wait its turn
          if (pulse_in) begin
            if (pending_cnt == PEND_TOP) overflow <= 1'b1;
            else                         pending_cnt <= pending_cnt + 1'b1;
          end
        end

        GAP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
            if (pulse_in) begin
              if (pending_cnt == PEND_TOP) overflow <= 1'b1;
              else                         pending_cnt <= pending_cnt + 1'b1;
            end
          end else if (pending_cnt != '0) begin
            // Replay the oldest queued event; a simultaneous new event takes
            // the freed slot, so the count only drops when nothing arrives
            state     <= HOLD;
            cnt       <= HOLD_LD;
            out_level <= 1'b1;
            if (!pulse_in) pending_cnt <= pending_cnt - 1'b1;
          end else if (pulse_in) begin
            // Nothing queued: the new event starts immediately, no idle cycle
            state     <= HOLD;
            cnt       <= HOLD_LD;
            out_level <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          cnt         <= '0;
          out_level   <= 1'b0;
          busy        <= 1'b0;
          pending_cnt <= '0;
        end
      endcase
    end
  end

endmodule
